// File: rtl/drvr_fifo_pkg.sv
// Shared constants and helpers for the per-driver transmit FIFO and its bus neighbours.
package drvr_fifo_pkg;

    localparam logic [7:0] BRDCST = 8'hFF;

    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_WR   = 2'b01,
        OP_POP  = 2'b10,
        OP_BOTH = 2'b11
    } op_e;

    // Occupancy counter needs one extra bit so that "full" (count == depth) is representable.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/drvr_fifo_if.sv
// Handshake bundle between the driver agent / bus controller (master) and drvr_fifo (slave).
interface drvr_fifo_if
    import drvr_fifo_pkg::*;
#(
    parameter int PCKG_SZ = 16,
    parameter int DEPTH   = 8
) ();
    localparam int CW = cnt_w(DEPTH);

    logic               wr;
    logic [PCKG_SZ-1:0] d_in;
    logic               full;
    logic               pop;
    logic [PCKG_SZ-1:0] d_pop;
    logic               pndng;
    logic [CW-1:0]      count;
    logic               ovrflw;
    logic               undrflw;
    logic [7:0]         drop_cnt;

    modport master (
        output wr, d_in, pop,
        input  full, d_pop, pndng, count, ovrflw, undrflw, drop_cnt
    );

    modport slave (
        input  wr, d_in, pop,
        output full, d_pop, pndng, count, ovrflw, undrflw, drop_cnt
    );
endinterface

// File: rtl/drvr_fifo_sat_cntr.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
module sat_cntr #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/drvr_fifo.sv
// First-word-fall-through transmit FIFO for one driver, with overflow/underflow
// pulses and a saturating dropped-packet counter.
module drvr_fifo
    import drvr_fifo_pkg::*;
#(
    parameter int PCKG_SZ = 16,
    parameter int DEPTH   = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    drvr_fifo_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [PCKG_SZ-1:0] mem [DEPTH];

    logic [PW-1:0] wp_q, wp_d;
    logic [PW-1:0] rp_q, rp_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovrflw_q, ovrflw_d;
    logic          undrflw_q, undrflw_d;

    logic empty;
    logic is_full;
    logic do_wr;
    logic do_pop;
    logic drop;
    op_e  op;

    assign empty   = (count_q == '0);
    assign is_full = (count_q == CW'(DEPTH));
    assign op      = op_e'({bus.pop, bus.wr});

    // A pop on a full FIFO frees the head slot, which is exactly where wp points,
    // so a simultaneous write is always accepted in that case.
    always_comb begin
        do_wr     = 1'b0;
        do_pop    = 1'b0;
        drop      = 1'b0;
        ovrflw_d  = 1'b0;
        undrflw_d = 1'b0;
        case (op)
            OP_WR: begin
                if (is_full) begin
                    drop     = 1'b1;
                    ovrflw_d = 1'b1;
                end else begin
                    do_wr = 1'b1;
                end
            end
            OP_POP: begin
                if (empty) begin
                    undrflw_d = 1'b1;
                end else begin
                    do_pop = 1'b1;
                end
            end
            OP_BOTH: begin
                do_wr = 1'b1;
                if (empty) begin
                    undrflw_d = 1'b1;
                end else begin
                    do_pop = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        wp_d    = wp_q + PW'(do_wr);
        rp_d    = rp_q + PW'(do_pop);
        count_d = count_q + CW'(do_wr) - CW'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q      <= '0;
            rp_q      <= '0;
            count_q   <= '0;
            ovrflw_q  <= 1'b0;
            undrflw_q <= 1'b0;
        end else begin
            wp_q      <= wp_d;
            rp_q      <= rp_d;
            count_q   <= count_d;
            ovrflw_q  <= ovrflw_d;
            undrflw_q <= undrflw_d;
        end
    end

    // Storage is deliberately not reset; a zero count masks stale contents.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wp_q] <= bus.d_in;
        end
    end

    sat_cntr #(.W(8)) u_drop_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (drop),
        .cnt_o (bus.drop_cnt)
    );

    assign bus.count   = count_q;
    assign bus.pndng   = !empty;
    assign bus.full    = is_full;
    assign bus.d_pop   = empty ? '0 : mem[rp_q];
    assign bus.ovrflw  = ovrflw_q;
    assign bus.undrflw = undrflw_q;
endmodule

// File: tb/tb_drvr_fifo.sv
// Randomised and directed bench for drvr_fifo against a queue-based reference model.
module tb_drvr_fifo;
    localparam int PCKG_SZ = 16;
    localparam int DEPTH   = 8;

    logic clk;
    logic rst_n;
    bit   check_en;
    int   checks;
    int   failures;

    logic [PCKG_SZ-1:0] mq [$];
    int                 m_drop;
    bit                 m_ovr;
    bit                 m_und;

    drvr_fifo_if #(.PCKG_SZ(PCKG_SZ), .DEPTH(DEPTH)) bus ();

    drvr_fifo #(.PCKG_SZ(PCKG_SZ), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference behaviour: a bounded queue plus flag/counter bookkeeping.
    always @(posedge clk) begin
        if (rst_n) begin
            bit accept;
            bit take;
            accept = 1'b0;
            take   = 1'b0;
            m_ovr  = 1'b0;
            m_und  = 1'b0;
            if (bus.pop) begin
                if (mq.size() == 0) m_und = 1'b1;
                else                take  = 1'b1;
            end
            if (bus.wr) begin
                if (mq.size() < DEPTH || take) accept = 1'b1;
                else begin
                    m_ovr = 1'b1;
                    if (m_drop < 255) m_drop++;
                end
            end
            if (take)   void'(mq.pop_front());
            if (accept) mq.push_back(bus.d_in);
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            logic [PCKG_SZ-1:0] exp_head;
            exp_head = (mq.size() != 0) ? mq[0] : '0;
            chk("count",    32'(bus.count),    32'(mq.size()));
            chk("pndng",    32'(bus.pndng),    32'(mq.size() != 0));
            chk("full",     32'(bus.full),     32'(mq.size() == DEPTH));
            chk("d_pop",    32'(bus.d_pop),    32'(exp_head));
            chk("ovrflw",   32'(bus.ovrflw),   32'(m_ovr));
            chk("undrflw",  32'(bus.undrflw),  32'(m_und));
            chk("drop_cnt", 32'(bus.drop_cnt), 32'(m_drop));
        end
    end

    task automatic step(input logic w, input logic [PCKG_SZ-1:0] d, input logic p);
        bus.wr   = w;
        bus.d_in = d;
        bus.pop  = p;
        @(posedge clk);
        @(negedge clk);
        bus.wr  = 1'b0;
        bus.pop = 1'b0;
    endtask

    initial begin
        logic [PCKG_SZ-1:0] t1 [3];
        logic [PCKG_SZ-1:0] got;
        t1 = '{16'h0A11, 16'h0B22, 16'h0C33};
        checks   = 0;
        failures = 0;
        check_en = 1'b0;
        m_drop   = 0;
        m_ovr    = 1'b0;
        m_und    = 1'b0;
        rst_n    = 1'b0;
        bus.wr   = 1'b0;
        bus.pop  = 1'b0;
        bus.d_in = '0;

        repeat (2) @(negedge clk);
        chk("rst_pndng", 32'(bus.pndng), 32'd0);
        chk("rst_full",  32'(bus.full),  32'd0);
        chk("rst_d_pop", 32'(bus.d_pop), 32'd0);
        chk("rst_count", 32'(bus.count), 32'd0);
        rst_n    = 1'b1;
        check_en = 1'b1;

        // In-order delivery of three packets
        for (int i = 0; i < 3; i++) step(1'b1, t1[i], 1'b0);
        chk("t1_count", 32'(bus.count), 32'd3);
        chk("t1_head",  32'(bus.d_pop), 32'h0A11);
        for (int i = 0; i < 3; i++) begin
            chk("t1_pop_order", 32'(bus.d_pop), 32'(t1[i]));
            step(1'b0, '0, 1'b1);
        end
        chk("t1_pndng_end", 32'(bus.pndng), 32'd0);
        chk("t1_d_pop_end", 32'(bus.d_pop), 32'd0);
        $display("phase order done checks=%0d", checks);

        // Overflow on a full FIFO
        for (int i = 0; i < DEPTH; i++) step(1'b1, 16'h1000 + 16'(i), 1'b0);
        chk("t2_full", 32'(bus.full), 32'd1);
        step(1'b1, 16'hDEAD, 1'b0);
        chk("t2_ovrflw", 32'(bus.ovrflw),   32'd1);
        chk("t2_drop",   32'(bus.drop_cnt), 32'd1);
        chk("t2_count",  32'(bus.count),    32'd8);
        step(1'b0, '0, 1'b0);
        chk("t2_ovrflw_pulse", 32'(bus.ovrflw), 32'd0);
        $display("phase overflow done checks=%0d", checks);

        // Write+pop while full
        step(1'b1, 16'hBEEF, 1'b1);
        chk("t3_count",  32'(bus.count),  32'd8);
        chk("t3_ovrflw", 32'(bus.ovrflw), 32'd0);
        chk("t3_head",   32'(bus.d_pop),  32'h1001);
        for (int i = 0; i < DEPTH; i++) begin
            got = bus.d_pop;
            if (i == DEPTH - 1) chk("t3_beef_8th", 32'(got), 32'hBEEF);
            step(1'b0, '0, 1'b1);
        end
        $display("phase full_wr_pop done checks=%0d", checks);

        // Underflow, alone and with a simultaneous write
        step(1'b0, '0, 1'b1);
        chk("t4_undrflw", 32'(bus.undrflw), 32'd1);
        step(1'b1, 16'hFF01, 1'b1);
        chk("t4_undrflw_wr", 32'(bus.undrflw), 32'd1);
        chk("t4_count",      32'(bus.count),   32'd1);
        chk("t4_head",       32'(bus.d_pop),   32'hFF01);
        step(1'b0, '0, 1'b1);
        $display("phase underflow done checks=%0d", checks);

        // Drop counter saturation, then ordering across the pointer wrap
        for (int i = 0; i < DEPTH; i++) step(1'b1, PCKG_SZ'($urandom), 1'b0);
        repeat (300) step(1'b1, PCKG_SZ'($urandom), 1'b0);
        chk("t5_drop_sat", 32'(bus.drop_cnt), 32'd255);
        for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1);
        step(1'b1, PCKG_SZ'($urandom), 1'b0);
        repeat (20) step(1'b1, PCKG_SZ'($urandom), 1'b1);
        step(1'b0, '0, 1'b1);
        chk("t5_empty", 32'(bus.count), 32'd0);
        $display("phase saturate_wrap done checks=%0d", checks);

        // Random traffic
        repeat (400) begin
            step(1'($urandom_range(0, 1)), PCKG_SZ'($urandom), 1'($urandom_range(0, 1)));
        end
        $display("phase random done checks=%0d", checks);

        // Asynchronous reset mid-stream
        for (int i = 0; i <= DEPTH; i++) begin
            if (bus.pndng) step(1'b0, '0, 1'b1);
        end
        for (int i = 0; i < 5; i++) step(1'b1, 16'h5000 + 16'(i), 1'b0);
        chk("t6_count_pre", 32'(bus.count), 32'd5);
        #2;
        rst_n = 1'b0;
        mq.delete();
        m_drop = 0;
        m_ovr  = 1'b0;
        m_und  = 1'b0;
        #1;
        chk("t6_async_pndng", 32'(bus.pndng),    32'd0);
        chk("t6_async_count", 32'(bus.count),    32'd0);
        chk("t6_async_d_pop", 32'(bus.d_pop),    32'd0);
        chk("t6_async_drop",  32'(bus.drop_cnt), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 16'h1234, 1'b0);
        chk("t6_head_after", 32'(bus.d_pop), 32'h1234);
        chk("t6_count_after", 32'(bus.count), 32'd1);
        $display("phase async_reset done checks=%0d", checks);

        check_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/drvr_fifo.md
# drvr_fifo

Per-driver transmit FIFO sitting directly upstream of `bs_gnrt_n_rbtr`; one instance per driver index. It buffers packets written by the driver-side agent and presents them to the bus controller through the `pndng`/`pop`/`D_pop` handshake. It is first-word-fall-through, reports overflow and underflow, and keeps a saturating count of dropped packets.

## Interface

Parameters:
- `pckg_sz`, 16, packet width in bits; upper 8 bits are the destination ID (`{8{1'b1}}` = broadcast).
- `depth`, 8, number of entries; power of two, ≥ 2.

Ports:
- `clk`, input, 1, single clock; all state updates on rising edge.
- `rst`, input, 1, asynchronous, active-low reset.
- `wr`, input, 1, write strobe from the driver agent.
- `D_in`, input, `pckg_sz`, packet to enqueue when `wr`=1.
- `full`, output, 1, high when `count == depth`.
- `pop`, input, 1, dequeue request from the bus controller.
- `D_pop`, output, `pckg_sz`, head packet; 0 when empty.
- `pndng`, output, 1, high when `count != 0`.
- `count`, output, `$clog2(depth)+1`, current occupancy.
- `ovrflw`, output, 1, one-cycle pulse: a write was dropped.
- `undrflw`, output, 1, one-cycle pulse: a pop arrived while empty.
- `drop_cnt`, output, 8, saturating count of dropped writes.

## Operation

- Storage: `depth`-entry array, write pointer `wp`, read pointer `rp`, each `$clog2(depth)` bits. Pointers wrap naturally modulo `depth`.
- `count` is held as a register and is not derived from the pointers.
- Write only (`wr`=1, `pop`=0):
  - Not full: store `D_in` at `wp`, `wp++`, `count++`.
  - Full: drop the packet; `ovrflw` pulses; `drop_cnt++` unless it is 255; pointers unchanged.
- Pop only:
  - Not empty: `rp++`, `count--`.
  - Empty: no state change; `undrflw` pulses.
- Simultaneous `wr` and `pop`:
  - Non-empty, not full: both happen; `count` unchanged.
  - Full: pop frees the head and the write is accepted into the freed slot (`wp` == old `rp`). No overflow; `count` stays `depth`.
  - Empty: write accepted, pop ignored, `undrflw` pulses. There is no bypass, so the new packet appears on `D_pop` the next cycle.
- `D_pop = pndng ? mem[rp] : 0`. This is combinational from registers only, with no path from `wr`, `D_in` or `pop`.
- `pndng` and `full` are decoded from registered `count`.
- Packet contents are not inspected; broadcast packets are queued like any other.
- `drop_cnt` clears only on reset.

## Timing

- Reset (`rst`=0, asynchronous): `wp`=`rp`=0, `count`=0, `drop_cnt`=0, `ovrflw`=`undrflw`=0.
  - Outputs during reset: `pndng`=0, `full`=0, `D_pop`=0.
  - Memory contents are don't-care and are not cleared.
- Reset mid-operation discards all queued packets immediately. Synchronous operation resumes on the first rising edge after `rst` deasserts.
- Write-to-visible latency: 1 cycle. A packet written at edge N shows `pndng`=1 and valid `D_pop` after edge N.
- Pop latency: the bus controller samples `D_pop` in the same cycle it asserts `pop`. After that edge `D_pop` shows the next entry, or 0 if the FIFO is now empty.
- `ovrflw` and `undrflw` are registered and high for exactly the cycle following the offending edge.
- `full` and `count` reflect state after the most recent edge.
- Throughput: one write and one pop per cycle sustained.

## Structure

- Add broadcast ID constant `BRDCST = 8'hFF` to `quiz2_lib.v`, along with a helper macro for the `count` width (`$clog2(depth)+1`). `bs_gnrt_n_rbtr` and the bus controllers use the same constants.
- One sub-module, `sat_cntr`: an 8-bit saturating incrementer with async active-low reset, used for `drop_cnt`.
- Storage and pointer logic stay inline in `drvr_fifo`.
- The top level instantiates `drvr` copies, wiring `pndng[i]`, `pop[i]` and `D_pop[i]` to the arbiter.

## Test plan

- Reset, then write `16'h0A11`, `16'h0B22`, `16'h0C33`. Expect: `count`=3, `pndng`=1, `D_pop`=`16'h0A11`. Three pops return the values in order, then `pndng`=0 and `D_pop`=0.
- Fill `depth`=8 entries, then write `16'hDEAD`. Expect: `full`=1, `ovrflw` pulses 1 cycle, `drop_cnt`=1, `count`=8. `16'hDEAD` never appears on `D_pop`.
- While full, assert `wr`+`pop` together with `D_in`=`16'hBEEF`. Expect: `count` stays 8, no `ovrflw`, head advances. `16'hBEEF` emerges 8th.
- Pop while empty, also with simultaneous `wr` of `16'hFF01`. Expect: `undrflw` pulses each time. After the combined cycle `count`=1 and `D_pop`=`16'hFF01`.
- Perform 300 overflowed writes. Expect: `drop_cnt` saturates at 255. Then 20 wrap-around cycles with 1 write + 1 pop each keep data ordered across the pointer wrap.
- Assert `rst`=0 asynchronously mid-stream with `count`=5. Expect: `pndng`, `count`, `D_pop` and `drop_cnt` go to 0 immediately without waiting for a clock edge. The next write after release appears at the head.
